board_io_ctrl: RTL and testbench



---
 rtl/board_io_ctrl.sv | 126 ++++++++++++
 tb/tb_board_io_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - step-button debouncer and 4-digit multiplexed 7-segment display driver
module board_io_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_CYCLES     = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step_btn,
  input  logic        disp_sel,
  input  logic        half_sel,
  input  logic [31:0] pc_in,
  input  logic [31:0] reg_in,
  output logic        step_pulse,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW = $clog2(SCAN_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d, stable_dly_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          pulse_q;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   latch_q, latch_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          scan_wrap, frame_start;
  logic [31:0]   src_word;
  logic [15:0]   sel_half;
  logic [3:0]    nibble;

  // Debounce: a level change is accepted only after an unbroken run of differing samples
  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        stable_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  // Scan timing, frame latch and next values for the registered display outputs
  always_comb begin
    scan_wrap   = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SW'(1);
    idx_d       = scan_wrap ? idx_q + 2'd1 : idx_q;
    frame_start = (idx_q == 2'd0) && (scan_cnt_q == '0);
    src_word    = disp_sel ? reg_in : pc_in;
    sel_half    = half_sel ? src_word[31:16] : src_word[15:0];
    // The digit shown on the loading cycle uses the freshly loaded word so a frame never mixes values
    latch_d     = frame_start ? sel_half : latch_q;
    case (idx_q)
      2'd0:    nibble = latch_d[3:0];
      2'd1:    nibble = latch_d[7:4];
      2'd2:    nibble = latch_d[11:8];
      default: nibble = latch_d[15:12];
    endcase
    an_d = ~(4'b0001 << idx_q);
    dp_d = ~((idx_q == 2'd3) && half_sel);
    case (nibble)
      4'h0:    seg_d = 7'b1000000;
      4'h1:    seg_d = 7'b1111001;
      4'h2:    seg_d = 7'b0100100;
      4'h3:    seg_d = 7'b0110000;
      4'h4:    seg_d = 7'b0011001;
      4'h5:    seg_d = 7'b0010010;
      4'h6:    seg_d = 7'b0000010;
      4'h7:    seg_d = 7'b1111000;
      4'h8:    seg_d = 7'b0000000;
      4'h9:    seg_d = 7'b0010000;
      4'hA:    seg_d = 7'b0001000;
      4'hB:    seg_d = 7'b0000011;
      4'hC:    seg_d = 7'b1000110;
      4'hD:    seg_d = 7'b0100001;
      4'hE:    seg_d = 7'b0000110;
      default: seg_d = 7'b0001110;
    endcase
  end

  // State update: synchronizer, debouncer, rising-edge pulse, scan counters and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      deb_cnt_q    <= '0;
      pulse_q      <= 1'b0;
      scan_cnt_q   <= '0;
      idx_q        <= 2'd0;
      latch_q      <= 16'h0000;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else begin
      sync1_q      <= step_btn;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      deb_cnt_q    <= deb_cnt_d;
      pulse_q      <= stable_q & ~stable_dly_q;
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      latch_q      <= latch_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign step_pulse = pulse_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb/tb_board_io_ctrl.sv - scoreboard bench for board_io_ctrl with short debounce and scan periods
module tb_board_io_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        step_btn;
  logic        disp_sel;
  logic        half_sel;
  logic [31:0] pc_in;
  logic [31:0] reg_in;
  logic        step_pulse;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  board_io_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SCAN_CYCLES    (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .step_btn  (step_btn),
    .disp_sel  (disp_sel),
    .half_sel  (half_sel),
    .pc_in     (pc_in),
    .reg_in    (reg_in),
    .step_pulse(step_pulse),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pulse;
  } exp_t;

  exp_t        sb[$];
  int          vectors  = 0;
  int          fails    = 0;
  int          edge_no  = 0;
  int          pulse_at = -1;
  int          k        = 0;
  logic [15:0] frame    = 16'h0000;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // One clock: predict the outputs after this edge, push, clock, pop and compare
  task automatic tick();
    exp_t e;
    exp_t g;
    int   d;
    if (reset) begin
      e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, pulse: 1'b0};
      k = 0;
    end else begin
      if (k % 12 == 0) begin
        if (disp_sel) frame = half_sel ? reg_in[31:16] : reg_in[15:0];
        else          frame = half_sel ? pc_in[31:16]  : pc_in[15:0];
      end
      d       = (k / 3) % 4;
      e.an    = ~(4'b0001 << d);
      e.seg   = hex7(frame[4*d +: 4]);
      e.dp    = !((d == 3) && half_sel);
      e.pulse = ((edge_no + 1) == pulse_at);
      k++;
    end
    sb.push_back(e);
    @(posedge clock);
    edge_no++;
    #1;
    g = sb.pop_front();
    vectors++;
    assert (an === g.an) else begin
      fails++;
      $error("FAIL an edge %0d: observed %b expected %b", edge_no, an, g.an);
    end
    vectors++;
    assert (seg === g.seg) else begin
      fails++;
      $error("FAIL seg edge %0d: observed %b expected %b", edge_no, seg, g.seg);
    end
    vectors++;
    assert (dp === g.dp) else begin
      fails++;
      $error("FAIL dp edge %0d: observed %b expected %b", edge_no, dp, g.dp);
    end
    vectors++;
    assert (step_pulse === g.pulse) else begin
      fails++;
      $error("FAIL step_pulse edge %0d: observed %b expected %b", edge_no, step_pulse, g.pulse);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset    = 1'b1;
    step_btn = 1'b0;
    disp_sel = 1'b0;
    half_sel = 1'b0;
    pc_in    = 32'h0000_00A4;
    reg_in   = 32'h0000_0000;

    // Reset state, then two full frames of the pc lower half and the anode order
    run(2);
    reset = 1'b0;
    run(24);

    // Switch to reg_in upper half in the middle of a frame
    run(5);
    disp_sel = 1'b1;
    half_sel = 1'b1;
    reg_in   = 32'hBEEF_0000;
    run(30);

    // Clean press held for 20 cycles, then clean release
    step_btn = 1'b1;
    pulse_at = edge_no + 7;
    run(20);
    step_btn = 1'b0;
    run(10);

    // Bouncy press then bouncy release
    step_btn = 1'b1; tick();
    step_btn = 1'b0; tick();
    step_btn = 1'b1; tick();
    step_btn = 1'b0; tick();
    step_btn = 1'b1;
    pulse_at = edge_no + 7;
    run(15);
    step_btn = 1'b0; tick();
    step_btn = 1'b1; tick();
    step_btn = 1'b0; tick();
    step_btn = 1'b1; tick();
    step_btn = 1'b0;
    run(15);

    // Reset after three of four debounce samples with the button still held
    step_btn = 1'b1;
    run(5);
    reset = 1'b1;
    run(2);
    reset    = 1'b0;
    pulse_at = edge_no + 7;
    run(15);
    step_btn = 1'b0;
    run(8);

    // Lower half of reg_in
    disp_sel = 1'b1;
    half_sel = 1'b0;
    reg_in   = 32'h1234_C7D9;
    run(26);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
